// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the fetch/sequencing stage: FSM state encoding,
// the branch opcode and the branch condition codes, plus a small decode
// helper used by the top level.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_ISSUE,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [1:0] OP_BRANCH   = 2'b11;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_NZERO  = 2'b10;
  localparam logic [1:0] COND_HALT   = 2'b11;

  // Branch/halt words are resolved in the fetch unit and never reach the core.
  function automatic logic is_branch(input logic [15:0] word);
    return word[1:0] == OP_BRANCH;
  endfunction

endpackage

// File: rtl/fetch_unit_branch_eval.sv
// branch_eval
// Purely combinational branch resolution. Given the condition code, the
// branch target, the current pc and the core result bus, produces the pc
// to continue from and a halt flag.
// Ports:
//   cond    - branch condition code (instruction bits [3:2])
//   target  - branch target address
//   pc      - current program counter
//   d_out   - core result bus, the value tested by conditional branches
//   next_pc - pc to fetch next (target when taken, pc+1 otherwise, pc on halt)
//   halt    - high when the condition code is the halt code
module branch_eval
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [1:0]        cond,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       d_out,
  output logic [ADDR_W-1:0] next_pc,
  output logic              halt
);

  logic [ADDR_W-1:0] pc_inc;

  // pc+1 wraps naturally at 2^ADDR_W.
  assign pc_inc = pc + 1'b1;

  always_comb begin
    halt    = 1'b0;
    next_pc = pc_inc;
    case (cond)
      COND_ALWAYS: next_pc = target;
      COND_ZERO:   if (d_out == 16'd0) next_pc = target;
      COND_NZERO:  if (d_out != 16'd0) next_pc = target;
      COND_HALT: begin
        halt    = 1'b1;
        next_pc = pc;
      end
      default:     next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch and sequencing stage in front of the bitty core. Owns
// the program counter, reads 16-bit words from a synchronous instruction
// memory, resolves branch/halt words locally and hands every other word to
// the core with a one-cycle run pulse, then waits for the core's done.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   start                - level; leaves IDLE and begins fetching at pc
//   mem_rd_en, mem_addr  - instruction memory read strobe and address
//   mem_rdata            - instruction word, valid one cycle after mem_rd_en
//   d_instr              - instruction presented to the core
//   run                  - one-cycle start pulse to the core
//   done                 - core completion pulse (honoured only in EXEC)
//   d_out                - core result bus, tested by conditional branches
//   pc                   - current program counter
//   busy                 - high in every state except IDLE and HALT
//   halted               - high in HALT
//   retired              - instructions completed (core plus branches)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       d_instr,
  output logic              run,
  input  logic              done,
  input  logic [15:0]       d_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  // The WAIT state assumes exactly one cycle of memory read latency.
  if (MEM_LAT != 1) begin : g_mem_lat_check
    $error("fetch_unit only supports MEM_LAT == 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;

  logic [ADDR_W-1:0] br_next_pc;
  logic              br_halt;

  branch_eval #(
    .ADDR_W (ADDR_W)
  ) u_branch_eval (
    .cond    (instr_q[3:2]),
    .target  (instr_q[ADDR_W+3:4]),
    .pc      (pc_q),
    .d_out   (d_out),
    .next_pc (br_next_pc),
    .halt    (br_halt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Next state plus the pc / instruction / retired-count updates that go
  // with each transition.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT: begin
        instr_d = mem_rdata;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_branch(instr_q)) begin
          // Halt leaves pc and retired untouched.
          if (br_halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d      = br_next_pc;
            retired_d = retired_q + 16'd1;
            state_d   = ST_FETCH;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      // done arriving in the run cycle is deliberately not looked at here.
      ST_ISSUE:  state_d = ST_EXEC;
      ST_EXEC: begin
        if (done) begin
          pc_d      = pc_q + 1'b1;
          retired_d = retired_q + 16'd1;
          state_d   = ST_FETCH;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == ST_FETCH);
    mem_addr  = (state_q == ST_FETCH) ? pc_q : '0;
    run       = (state_q == ST_ISSUE);
    busy      = !(state_q inside {ST_IDLE, ST_HALT});
    halted    = (state_q == ST_HALT);
  end

  assign d_instr = instr_q;
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Scoreboard bench for fetch_unit. Directed programs are loaded into a
// model instruction memory; the expected fetch addresses (with the cycle
// gap from the previous fetch) and the expected run pulses are queued up
// front, and a monitor pops and compares them as the DUT presents them.
// End-of-program state is checked directly once the unit halts.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] d_instr;
  logic        run;
  logic        done;
  logic [15:0] d_out;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (8),
    .MEM_LAT (1)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .d_instr   (d_instr),
    .run       (run),
    .done      (done),
    .d_out     (d_out),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .retired   (retired)
  );

  // Synchronous instruction memory, one cycle read latency.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Core model: done pulses 3 cycles after run; d_out takes the executed
  // word as its result. coreStall keeps the core busy forever.
  logic [1:0] coreCnt;
  logic       coreDone;
  logic       coreStall;
  logic       spuriousDone;
  logic       spurIssue;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coreCnt  <= 2'd0;
      coreDone <= 1'b0;
      d_out    <= 16'd0;
    end else begin
      coreDone <= 1'b0;
      if (run) begin
        coreCnt <= 2'd2;
      end else if (coreCnt == 2'd2) begin
        coreCnt <= 2'd1;
      end else if (coreCnt == 2'd1 && !coreStall) begin
        coreCnt  <= 2'd0;
        coreDone <= 1'b1;
        d_out    <= d_instr;
      end
    end
  end

  assign done = coreDone | spuriousDone | (spurIssue & run);

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [7:0] addr;
    int         gap;
  } fetch_t;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } run_t;

  fetch_t expFetch[$];
  run_t   expRun[$];
  fetch_t monF;
  run_t   monR;

  int checkCount = 0;
  int passCount  = 0;
  int fetchCount = 0;
  int lastFetch  = 0;

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every fetch and run pulse against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_rd_en) begin
        fetchCount++;
        if (expFetch.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_fetch: got addr %h expected no fetch", mem_addr);
        end else begin
          monF = expFetch.pop_front();
          checkOutput("fetch_addr", {8'h00, mem_addr}, {8'h00, monF.addr});
          if (monF.gap != 0)
            checkOutput("fetch_gap", 16'(cycle - lastFetch), 16'(monF.gap));
        end
        lastFetch = cycle;
      end
      if (run) begin
        if (expRun.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_run: got instr %h expected no run", d_instr);
        end else begin
          monR = expRun.pop_front();
          checkOutput("run_instr", d_instr, monR.instr);
          checkOutput("run_pc", {8'h00, pc}, {8'h00, monR.pc});
        end
      end
    end
  end

  task automatic pushFetch(input logic [7:0] addr, input int gap);
    fetch_t f;
    f.addr = addr;
    f.gap  = gap;
    expFetch.push_back(f);
  endtask

  task automatic pushRun(input logic [15:0] instr, input logic [7:0] p);
    run_t r;
    r.instr = instr;
    r.pc    = p;
    expRun.push_back(r);
  endtask

  task automatic resetDut();
    rst_n        = 1'b0;
    start        = 1'b0;
    spuriousDone = 1'b0;
    spurIssue    = 1'b0;
    coreStall    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h000F;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitHalt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checkCount++;
      $display("[TB] FAIL halt_timeout: got no halt expected halt within %0d cycles", budget);
    end
  endtask

  task automatic checkEnd(input string tag, input logic [7:0] expPc,
                          input logic [15:0] expRetired);
    checkOutput({tag, "_halted"}, {15'd0, halted}, 16'd1);
    checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, "_pc"}, {8'h00, pc}, {8'h00, expPc});
    checkOutput({tag, "_retired"}, retired, expRetired);
    checkOutput({tag, "_fetch_left"}, 16'(expFetch.size()), 16'd0);
    checkOutput({tag, "_run_left"}, 16'(expRun.size()), 16'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"}, {8'h00, pc}, 16'h0000);
    checkOutput({tag, "_d_instr"}, d_instr, 16'h0000);
    checkOutput({tag, "_run"}, {15'd0, run}, 16'd0);
    checkOutput({tag, "_mem_rd_en"}, {15'd0, mem_rd_en}, 16'd0);
    checkOutput({tag, "_mem_addr"}, {8'h00, mem_addr}, 16'h0000);
    checkOutput({tag, "_retired"}, retired, 16'h0000);
    checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, "_halted"}, {15'd0, halted}, 16'd0);
  endtask

  initial begin
    int n;
    int fetchSnap;

    resetDut();
    checkResetValues("reset");

    // Straight-line code: three core words then halt at 3.
    mem[0] = 16'h1230;
    mem[1] = 16'h4561;
    mem[2] = 16'h7892;
    mem[3] = 16'h000F;
    pushFetch(8'h00, 0); pushFetch(8'h01, 7); pushFetch(8'h02, 7); pushFetch(8'h03, 7);
    pushRun(16'h1230, 8'h00); pushRun(16'h4561, 8'h01); pushRun(16'h7892, 8'h02);
    applyStimulus();
    waitHalt(200);
    checkEnd("line", 8'h03, 16'd3);
    checkOutput("line_d_instr", d_instr, 16'h000F);
    // start must not wake the unit from HALT.
    fetchSnap = fetchCount;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    checkOutput("halt_no_fetch", 16'(fetchCount), 16'(fetchSnap));
    checkOutput("halt_stays", {15'd0, halted}, 16'd1);
    checkOutput("halt_pc", {8'h00, pc}, 16'h0003);

    // Unconditional jump to 0x10.
    resetDut();
    mem[8'h00] = 16'h0103;
    mem[8'h10] = 16'h000F;
    pushFetch(8'h00, 0); pushFetch(8'h10, 3);
    applyStimulus();
    waitHalt(100);
    checkEnd("jump", 8'h10, 16'd1);

    // Conditional branches, both conditions against zero and non-zero d_out.
    resetDut();
    mem[8'h00] = 16'h0207;
    mem[8'h20] = 16'h0005;
    mem[8'h21] = 16'h0407;
    mem[8'h22] = 16'h030B;
    mem[8'h30] = 16'h0000;
    mem[8'h31] = 16'h050B;
    mem[8'h32] = 16'h000F;
    pushFetch(8'h00, 0); pushFetch(8'h20, 3); pushFetch(8'h21, 7); pushFetch(8'h22, 3);
    pushFetch(8'h30, 3); pushFetch(8'h31, 7); pushFetch(8'h32, 3);
    pushRun(16'h0005, 8'h20); pushRun(16'h0000, 8'h30);
    applyStimulus();
    waitHalt(300);
    checkEnd("cond", 8'h32, 16'd6);

    // pc wrap at 0xFF, plus spurious done in IDLE and in the run cycle.
    resetDut();
    mem[8'h00] = 16'h0FF7;
    mem[8'hFF] = 16'h0005;
    mem[8'h01] = 16'h000F;
    @(negedge clk);
    spuriousDone = 1'b1;
    @(negedge clk);
    spuriousDone = 1'b0;
    checkOutput("idle_done_busy", {15'd0, busy}, 16'd0);
    checkOutput("idle_done_retired", retired, 16'd0);
    spurIssue = 1'b1;
    pushFetch(8'h00, 0); pushFetch(8'hFF, 3); pushFetch(8'h00, 7); pushFetch(8'h01, 3);
    pushRun(16'h0005, 8'hFF);
    applyStimulus();
    waitHalt(200);
    checkEnd("wrap", 8'h01, 16'd3);

    // Reset while the core is still executing.
    resetDut();
    mem[0] = 16'h1230;
    mem[1] = 16'h000F;
    coreStall = 1'b1;
    pushFetch(8'h00, 0);
    pushRun(16'h1230, 8'h00);
    applyStimulus();
    n = 0;
    while (!run && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkOutput("exec_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge clk);
    rst_n     = 1'b1;
    coreStall = 1'b0;
    pushFetch(8'h00, 0); pushFetch(8'h01, 7);
    pushRun(16'h1230, 8'h00);
    applyStimulus();
    waitHalt(200);
    checkEnd("rerun", 8'h01, 16'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
